// File: rtl/sort_pkg.sv
// Shared types and defaults for the sort sequencer and its snapshot store.
package sort_pkg;

    localparam int N_DEF      = 64;
    localparam int DW_DEF     = 8;
    localparam int AW_DEF     = 8;
    localparam int SETTLE_DEF = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_LOAD,
        ST_SETTLE,
        ST_DRAIN
    } state_t;

    // Width of a packed bus holding n slices of w bits.
    function automatic int bus_w(input int n, input int w);
        return n * w;
    endfunction

    // Counter width for 0..n inclusive (n is a power of two).
    function automatic int cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/sort_snapshot.sv
// Capture registers for the Sorter's packed outputs plus the drain read mux.
module sort_snapshot
    import sort_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    localparam int LW = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cap,
    input  logic [bus_w(N, DW)-1:0]   sorted_data,
    input  logic [bus_w(N, AW)-1:0]   sorted_addr,
    input  logic [LW-1:0]             sel,
    output logic [DW-1:0]             snap_data,
    output logic [AW-1:0]             snap_addr
);

    logic [bus_w(N, DW)-1:0] data_q;
    logic [bus_w(N, AW)-1:0] addr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            data_q <= '0;
            addr_q <= '0;
        end else if (cap) begin
            data_q <= sorted_data;
            addr_q <= sorted_addr;
        end
    end

    assign snap_data = data_q[sel * DW +: DW];
    assign snap_addr = addr_q[sel * AW +: AW];

endmodule

// File: rtl/sort_ctrl.sv
// Sequencer that loads N memory words into an external Sorter, snapshots the
// sorted result and drains it as (data, addr) pairs over a valid/ready stream.
//
// state    | meaning
// ---------|---------------------------------------------------------------
// IDLE     | Sorter held in reset, waiting for start
// PREFETCH | issue read of word 0 so data lines up with the first load
// LOAD     | stream word k with index k into the Sorter, read word k+1
// SETTLE   | hold Sorter inputs, snapshot on the last settle edge
// DRAIN    | present snapshot entry idx until out_ready, Sorter in reset
module sort_ctrl
    import sort_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     rd_en,
    output logic [AW-1:0]            rd_addr,
    input  logic [DW-1:0]            rd_data,
    output logic                     sorter_rst,
    output logic [DW-1:0]            sorter_data,
    output logic [AW-1:0]            sorter_addr,
    input  logic [bus_w(N, DW)-1:0]  sorted_data,
    input  logic [bus_w(N, AW)-1:0]  sorted_addr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data,
    output logic [AW-1:0]            out_addr,
    output logic                     out_last
);

    localparam int CW  = cnt_w(N);
    localparam int LW  = $clog2(N);
    localparam int STW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t          state, state_nxt;
    logic [CW-1:0]   k, idx;
    logic [STW-1:0]  settle_cnt;
    logic [DW-1:0]   hold_data;
    logic [AW-1:0]   hold_addr;
    logic            done_q;
    logic            load_last, idx_last, settle_tc, hs, cap;
    logic [LW-1:0]   k_inc;
    logic [DW-1:0]   snap_data;
    logic [AW-1:0]   snap_addr;

    assign load_last = (k == CW'(N - 1));
    assign idx_last  = (idx == CW'(N - 1));
    assign settle_tc = (settle_cnt == '0);
    assign k_inc     = k[LW-1:0] + LW'(1);
    assign hs        = out_valid & out_ready;
    assign cap       = (state == ST_SETTLE) && settle_tc;

    sort_snapshot #(
        .N  (N),
        .DW (DW),
        .AW (AW)
    ) u_snapshot (
        .clk         (clk),
        .rst         (rst),
        .cap         (cap),
        .sorted_data (sorted_data),
        .sorted_addr (sorted_addr),
        .sel         (idx[LW-1:0]),
        .snap_data   (snap_data),
        .snap_addr   (snap_addr)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            k          <= '0;
            idx        <= '0;
            settle_cnt <= '0;
            hold_data  <= '0;
            hold_addr  <= '0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == ST_DRAIN) && hs && idx_last;
            case (state)
                ST_PREFETCH: k <= '0;
                ST_LOAD: begin
                    k         <= k + 1'b1;
                    hold_data <= rd_data;
                    hold_addr <= AW'(k[LW-1:0]);
                    if (load_last)
                        settle_cnt <= STW'(SETTLE - 1);
                end
                ST_SETTLE: begin
                    if (!settle_tc)
                        settle_cnt <= settle_cnt - 1'b1;
                    else
                        idx <= '0;
                end
                ST_DRAIN: if (hs) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        busy        = 1'b1;
        done        = 1'b0;
        rd_en       = 1'b0;
        rd_addr     = '0;
        sorter_rst  = 1'b1;
        sorter_data = '0;
        sorter_addr = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_addr    = '0;
        out_last    = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                done = done_q;
                if (start)
                    state_nxt = ST_PREFETCH;
            end
            ST_PREFETCH: begin
                rd_en     = 1'b1;
                state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                sorter_rst  = 1'b0;
                sorter_data = rd_data;
                sorter_addr = AW'(k[LW-1:0]);
                if (!load_last) begin
                    rd_en   = 1'b1;
                    rd_addr = AW'(k_inc);
                end else begin
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                sorter_rst  = 1'b0;
                sorter_data = hold_data;
                sorter_addr = hold_addr;
                if (settle_tc)
                    state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                out_valid = 1'b1;
                out_data  = snap_data;
                out_addr  = snap_addr;
                out_last  = idx_last;
                if (out_ready && idx_last)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset wins immediately so an abort never leaks a partial drain.
        if (!rst) begin
            state_nxt   = ST_IDLE;
            busy        = 1'b0;
            done        = 1'b0;
            rd_en       = 1'b0;
            rd_addr     = '0;
            sorter_rst  = 1'b1;
            sorter_data = '0;
            sorter_addr = '0;
            out_valid   = 1'b0;
            out_data    = '0;
            out_addr    = '0;
            out_last    = 1'b0;
        end
    end

endmodule

// File: tb/tb_sort_ctrl.sv
// Scoreboard bench for sort_ctrl with a behavioural Sorter and source memory.
module tb_sort_ctrl;

    localparam int N      = 64;
    localparam int DW     = 8;
    localparam int AW     = 8;
    localparam int SETTLE = 3;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          l;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              busy, done, rd_en, sorter_rst, out_valid, out_last;
    logic              out_ready = 1'b1;
    logic [AW-1:0]     rd_addr, sorter_addr, out_addr;
    logic [DW-1:0]     rd_data = '0;
    logic [DW-1:0]     sorter_data, out_data;
    logic [N*DW-1:0]   sorted_data = '0;
    logic [N*AW-1:0]   sorted_addr = '0;

    logic [DW-1:0]     mem [N];
    logic [DW-1:0]     m_val [N];
    exp_t              sb [$];
    int                rd_log [$];
    int                total = 0, bad = 0;
    int                cyc = 0, c_start = 0, first_ov_cyc = -1, srl_cnt = 0;
    int                hs_cnt = 0, ready_mode = 0, stall_left = 0;
    bit                stalled31 = 0, done_due = 0, ov_prev = 0, stall_prev = 0;
    logic [31:0]       stall_val = '0;

    sort_ctrl #(.N(N), .DW(DW), .AW(AW), .SETTLE(SETTLE)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .sorter_rst  (sorter_rst),
        .sorter_data (sorter_data),
        .sorter_addr (sorter_addr),
        .sorted_data (sorted_data),
        .sorted_addr (sorted_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_last    (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    // Sorter stand-in: stores by index, presents ascending by rank (ties by index).
    always @(posedge clk) begin
        if (sorter_rst) for (int i = 0; i < N; i++) m_val[i] <= '0;
        else m_val[sorter_addr] <= sorter_data;
    end

    always @(negedge clk) begin : sorter_view
        int r;
        for (int i = 0; i < N; i++) begin
            r = 0;
            for (int j = 0; j < N; j++)
                if (m_val[j] < m_val[i] || (m_val[j] == m_val[i] && j < i)) r++;
            sorted_data[DW*r +: DW] = m_val[i];
            sorted_addr[AW*r +: AW] = AW'(i);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) out_ready = 1'b1;
        else if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (hs_cnt == 31 && !stalled31 && out_valid) begin
            stalled31 = 1;
            stall_left = 9;
            out_ready = 1'b0;
        end else out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (done_due) begin
                chk("done_pulse", 32'(done), 1);
                done_due = 0;
            end else if (done) chk("done_spurious", 32'(done), 0);
            if (out_valid && !ov_prev) first_ov_cyc = cyc;
            if (!sorter_rst) srl_cnt++;
            if (rd_en) rd_log.push_back(int'(rd_addr));
            if (out_valid && !out_ready) begin
                if (stall_prev) chk("stall_hold", 32'({out_data, out_addr, out_last}), stall_val);
                stall_val = 32'({out_data, out_addr, out_last});
            end
            stall_prev = out_valid && !out_ready;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("sb_underflow", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.d));
                    chk("out_addr", 32'(out_addr), 32'(e.a));
                    chk("out_last", 32'(out_last), 32'(e.l));
                end
                hs_cnt++;
                if (out_last) done_due = 1;
            end
            ov_prev = out_valid;
        end else begin
            done_due = 0;
            stall_prev = 0;
            ov_prev = 0;
        end
    end

    task automatic load_mem(input int pat);
        for (int i = 0; i < N; i++)
            case (pat)
                0:       mem[i] = DW'((i * 37 + 11) ^ (i >> 1));
                1:       mem[i] = 8'h5A;
                default: mem[i] = DW'(63 - i);
            endcase
    endtask

    // Expected drain: values ascending, equal values in index order.
    task automatic push_expect();
        exp_t e;
        int n = 0;
        for (int v = 0; v < 256; v++)
            for (int i = 0; i < N; i++)
                if (int'(mem[i]) == v) begin
                    e.d = DW'(v);
                    e.a = AW'(i);
                    e.l = (n == N - 1);
                    sb.push_back(e);
                    n++;
                end
    endtask

    task automatic begin_job();
        rd_log.delete();
        srl_cnt = 0;
        hs_cnt = 0;
        stalled31 = 0;
        first_ov_cyc = -1;
        push_expect();
        start = 1'b1;
    endtask

    task automatic kick();
        @(posedge clk); #1;
        begin_job();
        @(negedge clk);
        c_start = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic finish_job(input bit chain, input int next_pat);
        int errs = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", 32'(done), 1);
        chk("first_valid_latency", 32'(first_ov_cyc - c_start), N + 2 + SETTLE);
        chk("sorter_rst_low_cycles", 32'(srl_cnt), N + SETTLE);
        chk("rd_count", 32'(rd_log.size()), N);
        foreach (rd_log[j]) if (rd_log[j] != j) errs++;
        chk("rd_seq_errors", 32'(errs), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        if (chain) begin
            load_mem(next_pat);
            begin_job();
            c_start = cyc;
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            chk("chain_prefetch", 32'({busy, rd_en, sorter_rst, rd_addr}), 32'({3'b111, 8'h00}));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ctrl", 32'({busy, done, rd_en, sorter_rst, out_valid, out_last}), 32'(6'b000100));
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_sorter_bus", 32'({sorter_data, sorter_addr}), 0);
        chk("rst_out_bus", 32'({out_data, out_addr}), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Job A: mixed data, extra start pulses during LOAD and DRAIN.
        load_mem(0);
        kick();
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        finish_job(0, 0);
        repeat (3) @(negedge clk);
        chk("no_queued_start", 32'(busy), 0);

        // Job B: all equal, chained into job C (reversed) in the done cycle.
        load_mem(1);
        kick();
        finish_job(1, 2);
        ready_mode = 1;
        finish_job(0, 0);
        ready_mode = 0;

        // Abort at LOAD k=20, then a fresh full job.
        load_mem(0);
        kick();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!sorter_rst && sorter_addr == 8'd20) break;
        end
        chk("abort_point", 32'(sorter_addr), 20);
        rst = 1'b0;
        #1 chk("abort_outs", 32'({busy, sorter_rst, out_valid}), 32'(3'b010));
        @(posedge clk); #1 rst = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("abort_idle", 32'({busy, sorter_rst, out_valid, done}), 32'(4'b0100));
        repeat (150) @(negedge clk);
        load_mem(0);
        kick();
        finish_job(0, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sort_ctrl.md
Name: sort_ctrl

Overview:
Sequencer wrapped around the existing Sorter datapath (N entries, packed sorted_data/sorted_addr outputs, active-high reset, one sample per clock).
- On a start pulse, it reads N samples from a synchronous source memory and streams them into the Sorter with their indices.
- After load plus settle it snapshots the Sorter's packed outputs and parks the Sorter in reset.
- It then drains the sorted (data, addr) pairs one per handshake on a valid/ready output stream.

Parameters:
N, 64, number of entries; must equal the Sorter instance parameter; power of two, ≥2.
DW, 8, data width.
AW, 8, index width carried to the Sorter and output; 2^AW ≥ N.
SETTLE, 1, extra cycles after the last load cycle before snapshot (≥1).

Ports:
clk  in  1  single clock, all logic on rising edge.
rst  in  1  synchronous, active-low reset (0 = reset).
start  in  1  begin a sort job; sampled only in IDLE.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse after the final output handshake.
rd_en  out  1  source memory read enable.
rd_addr  out  AW  source memory read address.
rd_data  in  DW  source memory data, valid one cycle after rd_en.
sorter_rst  out  1  active-high reset to the Sorter.
sorter_data  out  DW  Sorter data input.
sorter_addr  out  AW  Sorter index input.
sorted_data  in  DW*N  packed Sorter data; entry i = bits [DW*i+DW-1 -: DW].
sorted_addr  in  AW*N  packed Sorter indices, same packing.
out_valid  out  1  output entry valid.
out_ready  in  1  downstream accept.
out_data  out  DW  sorted data for entry idx.
out_addr  out  AW  original index for entry idx.
out_last  out  1  high with out_valid when idx == N-1.

Behaviour:
- Reset (rst=0 at an edge) forces state IDLE and clears all counters. Outputs while in reset: busy=0, done=0, rd_en=0, rd_addr=0, sorter_rst=1, sorter_data=0, sorter_addr=0, out_valid=0, out_last=0, out_data=0, out_addr=0.
- Reset mid-job aborts immediately and discards any partial drain; no done pulse.
- States:
  - IDLE: sorter_rst=1. start=1 → PREFETCH.
  - PREFETCH (1 cycle): rd_en=1, rd_addr=0, sorter_rst=1 → LOAD with k=0.
  - LOAD (N cycles, k=0..N-1): sorter_rst=0, sorter_addr=k, sorter_data=rd_data (memory word k). rd_en=1 and rd_addr=k+1 while k<N-1; rd_en=0 on the last cycle. k==N-1 → SETTLE.
  - SETTLE (SETTLE cycles): sorter_rst=0, sorter_data/sorter_addr hold their last values. On the edge ending the last SETTLE cycle, capture sorted_data and sorted_addr into snapshot registers → DRAIN with idx=0.
  - DRAIN: sorter_rst=1, out_valid=1, out_data/out_addr = snapshot entry idx, out_last=(idx==N-1).
    - out_valid&out_ready → idx+1.
    - Outputs held stable while out_ready=0.
    - Handshake with idx==N-1 → IDLE, and done=1 in that first IDLE cycle.
- Latency: if start is accepted at edge T, the first out_valid is in cycle T+2+N+SETTLE. Minimum job is 2+N+SETTLE+N cycles with out_ready held high.
- busy=1 in PREFETCH, LOAD, SETTLE and DRAIN.
- start outside IDLE is ignored and never queued. start in the IDLE cycle that carries done is accepted.
- Counters k and idx are log2(N)+1 bits wide with no wrap. sorter_addr and out_addr are zero-extended to AW.
- Drain order is Sorter entry 0 first. The controller does not reorder or compare.

Decomposition:
- Package sort_pkg holds:
  - the state enum (IDLE, PREFETCH, LOAD, SETTLE, DRAIN);
  - default N/DW/AW;
  - the packed-slice width constants.
- One sub-module, sort_snapshot: capture-enable registers for both packed buses plus the idx read mux.
- The FSM, counters and source/Sorter driving stay in sort_ctrl.
- The Sorter is instantiated alongside the controller by the parent, not inside it.

Test Plan:
- Memory = 64 values from Input_8bit_hex_64total.txt, out_ready=1, start pulse → 64 handshakes. out_data matches sorted_python.txt in order, out_addr is a permutation of 0..63 with mem[out_addr]==out_data, out_last only on the 64th handshake, done one cycle later.
- Memory all 0x5A → all out_data=0x5A and out_addr covers 0..63 exactly once. Memory reversed 0x3F..0x00 → out_data ascends 0x00..0x3F with out_addr = 63-out_data.
- out_ready toggled pseudo-randomly (and held low 10 cycles at idx=31) → out_data/out_addr/out_last stable while stalled, no entry lost or duplicated.
- start re-pulsed during LOAD and during DRAIN → ignored, rd_addr sequence 0..63 once. start in the done cycle → second job begins, PREFETCH on the next cycle.
- rst=0 for 1 cycle at LOAD k=20 → IDLE, sorter_rst=1, out_valid=0, no done. A fresh start then produces a correct full result.
- Check cycle timing with SETTLE=3: first out_valid exactly N+5 cycles after the start-accept edge, and sorter_rst low for exactly N+3 cycles.
